// File: rtl/cmp_seq_slice.sv
// Multi-cycle magnitude/equality comparator: walks two W-bit operands S bits
// per clock from the MSB end and stops at the first differing slice.
module cmp_seq_slice #(
  parameter int W = 16,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  localparam int N  = W / S;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((S < 1) || ((W % S) != 0)) begin : g_bad_slice_width
      $error("cmp_seq_slice: W must be a positive integer multiple of S");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [CW-1:0]  cnt;
  logic           signed_q;
  logic           first_slice;
  logic [S-1:0]   sl_a;
  logic [S-1:0]   sl_b;

  // Flipping both sign bits on the leading slice maps two's complement onto
  // offset binary, so a plain unsigned slice compare orders signed operands.
  always_comb begin
    first_slice = (cnt == CW'(N - 1));
    sl_a        = a_sh[W-1 -: S];
    sl_b        = b_sh[W-1 -: S];
    if (signed_q && first_slice) begin
      sl_a[S-1] = ~sl_a[S-1];
      sl_b[S-1] = ~sl_b[S-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      signed_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_tick <= 1'b0;
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            signed_q <= signed_mode;
            eq       <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            cnt      <= CW'(N - 1);
            ready    <= 1'b0;
            state    <= COMP;
          end
        end
        COMP: begin
          if (sl_a > sl_b) begin
            gt        <= 1'b1;
            done_tick <= 1'b1;
            state     <= DONE;
          end else if (sl_a < sl_b) begin
            lt        <= 1'b1;
            done_tick <= 1'b1;
            state     <= DONE;
          end else if (cnt == '0) begin
            eq        <= 1'b1;
            done_tick <= 1'b1;
            state     <= DONE;
          end else begin
            a_sh <= a_sh << S;
            b_sh <= b_sh << S;
            cnt  <= cnt - CW'(1);
          end
        end
        DONE: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_slice.sv
// Self-checking bench for cmp_seq_slice (W=16, S=4): directed cases from the
// test plan plus randomized compares against an arithmetic reference model.
module tb_cmp_seq_slice;

  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done_tick;
  logic         eq;
  logic         gt;
  logic         lt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_done   = 0;

  cmp_seq_slice #(.W(W), .S(S)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .ready(ready), .done_tick(done_tick),
    .eq(eq), .gt(gt), .lt(lt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Latency in edges: 1-based index of the first differing slice from the MSB.
  function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = 0; i < N; i++)
      if (x[W-1-i*S -: S] != y[W-1-i*S -: S]) return i + 1;
    return N;
  endfunction

  function automatic logic [2:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sm);
    logic is_gt, is_lt;
    if (sm) begin
      is_gt = $signed(x) > $signed(y);
      is_lt = $signed(x) < $signed(y);
    end else begin
      is_gt = x > y;
      is_lt = x < y;
    end
    return {x == y, is_gt, is_lt};
  endfunction

  // Waits for done_tick after an accepting edge; returns edges taken (0 on timeout).
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 1; i <= 2 * N + 4; i++) begin
      @(posedge clk); #1;
      if (done_tick) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic sm, input bit hold, input bit chk_space,
                               input string tag);
    int         edges;
    int         k;
    logic [2:0] expv;
    for (int i = 0; i < 50 && !ready; i++) begin
      @(posedge clk); #1;
    end
    a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
    k    = first_diff(ta, tb_v);
    expv = ref_result(ta, tb_v, sm);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    checkOutput({tag, "_busy"}, {ready, eq, gt, lt}, 4'b0000);
    wait_done(edges);
    checkOutput({tag, "_latency"}, edges, k);
    checkOutput({tag, "_result"}, {eq, gt, lt}, expv);
    checkOutput({tag, "_onehot"}, 32'(eq) + 32'(gt) + 32'(lt), 1);
    if (chk_space) checkOutput({tag, "_spacing"}, cyc - last_done, k + 2);
    last_done = cyc;
    @(posedge clk); #1;
    checkOutput({tag, "_idle"}, {ready, done_tick, eq, gt, lt}, {2'b10, expv});
  endtask

  initial begin
    int edges;
    int dones;
    logic [W-1:0] ra, rb;

    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {ready, done_tick, eq, gt, lt}, 5'b10000);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(16'h1234, 16'h1234, 1'b0, 0, 0, "uns_equal");
    applyStimulus(16'h8000, 16'h7FFF, 1'b0, 0, 0, "early_uns");
    applyStimulus(16'h8000, 16'h7FFF, 1'b1, 0, 0, "early_sgn");
    applyStimulus(16'h12A4, 16'h1294, 1'b0, 0, 0, "mid_word");
    applyStimulus(16'hFFFE, 16'hFFFF, 1'b1, 0, 0, "sgn_prefix_lt");
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 0, 0, "sgn_prefix_eq");

    // Start and operand changes while busy must not disturb the compare in flight.
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'h0000;
    wait_done(edges);
    start = 1'b0;
    checkOutput("ignored_start_latency", edges, 4);
    checkOutput("ignored_start_result", {eq, gt, lt}, 3'b001);
    dones = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_tick) dones++;
    end
    checkOutput("ignored_start_no_second", dones, 0);

    a = 16'h5555; b = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b1; #1;
    checkOutput("reset_abort", {ready, done_tick, eq, gt, lt}, 5'b10000);
    @(negedge clk); reset = 1'b0;
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_tick) dones++;
    end
    checkOutput("reset_abort_no_done", dones, 0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 0, 0, "post_reset_eq");

    applyStimulus(16'h4321, 16'h4321, 1'b0, 1, 0, "b2b_0");
    applyStimulus(16'h9000, 16'h1000, 1'b1, 1, 1, "b2b_1");
    applyStimulus(16'h0A00, 16'h0B00, 1'b0, 1, 1, "b2b_2");
    applyStimulus(16'hFF10, 16'hFF01, 1'b1, 1, 1, "b2b_3");
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = {ra[15:4], rb[3:0]};
        2: rb = {ra[15:8], rb[7:0]};
        default: ;
      endcase
      applyStimulus(ra, rb, 1'($urandom), 1'(i % 3 == 0), 0, "random");
    end
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmp_seq_slice.md
Name: cmp_seq_slice

Overview:
- Parametrised multi-cycle magnitude/equality comparator; successor to the single-bit equality cell.
- Compares two W-bit operands S bits per clock, most-significant slice first, and stops at the first differing slice.
- Produces one-hot eq/gt/lt with a start/ready/done_tick handshake.
- Sits beside datapath units that need wide compares without a wide combinational tree (timers, sorters, address match).

Parameters:
- W, 16, operand width in bits; must be an integer multiple of S.
- S, 4, slice width compared per clock; S=W gives single-cycle compare, S=1 gives bit-serial compare.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a compare; sampled only when ready=1
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; captured with start
- a  input  W  operand A; captured with start
- b  input  W  operand B; captured with start
- ready  output  1  high in IDLE only
- done_tick  output  1  one-clock pulse, result valid
- eq  output  1  a == b
- gt  output  1  a > b
- lt  output  1  a < b

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Outputs are all registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Reset values: state=IDLE, ready=1, done_tick=0, eq=0, gt=0, lt=0. Internal shift registers and the slice counter clear to 0.
- FSM states: IDLE, COMP, DONE.
- IDLE:
  - ready=1.
  - When start=1 at a rising edge:
    - load a, b and signed_mode into internal registers;
    - clear eq/gt/lt to 0;
    - load the slice counter with W/S-1;
    - go to COMP.
- COMP:
  - Each cycle, compare the top S bits of the A and B shift registers as unsigned values.
  - Signed mode: on the first slice only, invert the sign bit of both operands before comparing. This gives offset-binary order, so two's-complement ordering is correct.
  - Slices differ: set gt or lt, go to DONE.
  - Slices equal and counter=0: set eq=1, go to DONE.
  - Otherwise: shift both registers left by S, decrement the counter, stay in COMP.
- DONE:
  - done_tick=1 and ready=0 for exactly one cycle, then return to IDLE unconditionally.
  - eq/gt/lt hold their value until the next accepted start.
- Latency:
  - Let k be the 1-based index of the first mismatching slice, counted from the MSB; k=W/S if the operands are equal.
  - Results and done_tick appear k rising edges after the edge that accepted start.
  - Back-to-back throughput is one result every k+2 cycles.
- Result encoding: eq, gt, lt are mutually exclusive. Exactly one is high from the DONE cycle until the next accepted start. All three are 0 after reset and during COMP.
- start while ready=0 (COMP or DONE) is ignored. Operand or mode changes during COMP do not affect the result in flight.
- start high in the IDLE cycle immediately after DONE is accepted normally.
- Reset asserted mid-operation: aborts immediately to the reset values; no done_tick is issued for the aborted compare.
- W not a multiple of S is unsupported; the implementation flags it with an elaboration-time check.

Test Plan (W=16, S=4):
- Unsigned equal: a=16'h1234, b=16'h1234, signed_mode=0, start pulse -> eq=1, gt=lt=0, done_tick 4 edges after start, ready=1 on the following cycle.
- Early exit, both modes:
  - a=16'h8000, b=16'h7FFF, signed_mode=0 -> gt=1 after 1 edge.
  - Same operands with signed_mode=1 -> lt=1 after 1 edge.
- Mid-word mismatch: a=16'h12A4, b=16'h1294, unsigned -> gt=1, done_tick 3 edges after start.
- Signed equal-prefix ordering:
  - a=16'hFFFE, b=16'hFFFF, signed_mode=1 -> lt=1 after 4 edges.
  - a=b=16'hFFFF -> eq=1 after 4 edges.
- Ignored start: accept a=16'h0001, b=16'h0002. During COMP, drive start=1 with a=16'hFFFF, b=0 -> single lt=1 result after 4 edges, no second done_tick.
- Reset mid-compare: assert reset 2 cycles into COMP -> ready=1, eq=gt=lt=0, no done_tick. Then a=b=16'h0000 -> eq=1 after 4 edges.
- Back-to-back (all of the following):
  - start held high continuously -> successive compares each accepted in IDLE, done_tick spaced k+2 cycles apart.
  - Outputs are one-hot at every done_tick.
